clk_div_monitor: RTL and testbench

CLK_DIV_MONITOR -- requirements
Module: clk_div_monitor

---
 rtl/clk_div_monitor.sv | 158 +++++++++++++++
 tb/tb_clk_div_monitor.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_monitor.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// clk_div_monitor
//
// Measures the high and low phase lengths of a slow, asynchronous divided
// clock (sig_in), counted in cycles of the system clock. It publishes each
// complete period together with a 50%-duty check. It also flags an input that
// has stopped toggling for longer than the phase counters can represent.
//
// Ports
//   clk        system clock, all logic on its rising edge
//   rst        asynchronous, active-high reset
//   en         measurement enable (synchronous to clk)
//   sig_in     divided clock under measurement (asynchronous to clk)
//   high_cnt   clk cycles sig_in was high in the last complete period
//   low_cnt    clk cycles sig_in was low in the last complete period
//   period     high_cnt + low_cnt at full width
//   duty_ok    high_cnt and low_cnt differ by at most one
//   meas_valid one-cycle pulse when the result outputs update
//   stuck      sig_in held one level beyond the counter range
// -----------------------------------------------------------------------------
module clk_div_monitor #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] low_cnt,
  output logic [CNT_W:0]   period,
  output logic             duty_ok,
  output logic             meas_valid,
  output logic             stuck
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RISE,
    MEAS_HIGH,
    MEAS_LOW
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  logic             s1;
  logic             s2;
  logic             s3;
  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] lcnt;
  logic [CNT_W-1:0] cnt_diff;
  logic             duty_next;
  logic [CNT_W:0]   period_next;

  // The synchronizer runs regardless of en so that edge history is already
  // valid on the first enabled cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  // Result values for the period being closed. They are only used on the
  // cycle a rise ends MEAS_LOW, and at that point hcnt/lcnt hold the finished
  // counts.
  always_comb begin
    cnt_diff    = (hcnt >= lcnt) ? (hcnt - lcnt) : (lcnt - hcnt);
    duty_next   = (cnt_diff <= CNT_W'(1));
    period_next = {1'b0, hcnt} + {1'b0, lcnt};
  end

  // Measurement FSM. Dropping en wins over everything, including a rise on
  // the same cycle, so a period interrupted by disable is never published.
  // The saturation checks sit behind the edge checks. A phase that reaches
  // exactly CNT_MAX and then ends is still a legal measurement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      hcnt       <= '0;
      lcnt       <= '0;
      high_cnt   <= '0;
      low_cnt    <= '0;
      period     <= '0;
      duty_ok    <= 1'b0;
      meas_valid <= 1'b0;
      stuck      <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (!en) begin
        state <= IDLE;
        hcnt  <= '0;
        lcnt  <= '0;
      end else begin
        case (state)
          IDLE: begin
            state <= WAIT_RISE;
          end
          WAIT_RISE: begin
            if (rise) begin
              state <= MEAS_HIGH;
              hcnt  <= CNT_W'(1);
              lcnt  <= '0;
            end
          end
          MEAS_HIGH: begin
            if (fall) begin
              state <= MEAS_LOW;
              lcnt  <= CNT_W'(1);
            end else if (hcnt == CNT_MAX) begin
              state <= WAIT_RISE;
              stuck <= 1'b1;
              hcnt  <= '0;
              lcnt  <= '0;
            end else begin
              hcnt <= hcnt + CNT_W'(1);
            end
          end
          MEAS_LOW: begin
            if (rise) begin
              state      <= MEAS_HIGH;
              high_cnt   <= hcnt;
              low_cnt    <= lcnt;
              period     <= period_next;
              duty_ok    <= duty_next;
              meas_valid <= 1'b1;
              stuck      <= 1'b0;
              hcnt       <= CNT_W'(1);
              lcnt       <= '0;
            end else if (lcnt == CNT_MAX) begin
              state <= WAIT_RISE;
              stuck <= 1'b1;
              hcnt  <= '0;
              lcnt  <= '0;
            end else begin
              lcnt <= lcnt + CNT_W'(1);
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clk_div_monitor.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_clk_div_monitor
//
// Drives two monitors from the same stimulus: one at the default width and
// one with 4-bit counters, so that saturation is easy to reach. The reference
// model tracks the time stamps of the edges seen after synchronization. It
// derives phase lengths as differences between those time stamps.
// -----------------------------------------------------------------------------
module tb_clk_div_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        sig_in;

  logic [15:0] high16;
  logic [15:0] low16;
  logic [16:0] period16;
  logic        duty16;
  logic        valid16;
  logic        stuck16;

  logic [3:0]  high4;
  logic [3:0]  low4;
  logic [4:0]  period4;
  logic        duty4;
  logic        valid4;
  logic        stuck4;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int vcount16 = 0;

  // Reference model state: index 0 is the 16-bit monitor, index 1 the 4-bit one.
  bit [2:0] mhist;
  int       rise_t[2];
  int       fall_t[2];
  bit       live[2];
  int       cnt_max[2];
  int       exp_high[2];
  int       exp_low[2];
  int       exp_period[2];
  bit       exp_duty[2];
  bit       exp_valid[2];
  bit       exp_stuck[2];

  always #10 clk = ~clk;

  clk_div_monitor #(.CNT_W(16)) dut16 (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .sig_in     (sig_in),
    .high_cnt   (high16),
    .low_cnt    (low16),
    .period     (period16),
    .duty_ok    (duty16),
    .meas_valid (valid16),
    .stuck      (stuck16)
  );

  clk_div_monitor #(.CNT_W(4)) dut4 (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .sig_in     (sig_in),
    .high_cnt   (high4),
    .low_cnt    (low4),
    .period     (period4),
    .duty_ok    (duty4),
    .meas_valid (valid4),
    .stuck      (stuck4)
  );

  task automatic checkOutput(input string tag, input int obs, input int expv);
    checks++;
    if (obs != expv) begin
      failures++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, obs, expv);
    end
  endtask

  task automatic modelReset();
    mhist = 3'b000;
    for (int i = 0; i < 2; i++) begin
      rise_t[i]     = -1;
      fall_t[i]     = -1;
      live[i]       = 1'b0;
      exp_high[i]   = 0;
      exp_low[i]    = 0;
      exp_period[i] = 0;
      exp_duty[i]   = 1'b0;
      exp_valid[i]  = 1'b0;
      exp_stuck[i]  = 1'b0;
    end
  endtask

  // One clk rising edge of the model. The level seen by the measurement logic
  // lags sig_in by two samples. A period is a rise time stamp, a fall time
  // stamp and a closing rise.
  task automatic modelEdge();
    bit r;
    bit f;
    int h;
    int l;
    r = mhist[1] & ~mhist[2];
    f = ~mhist[1] & mhist[2];
    for (int i = 0; i < 2; i++) begin
      exp_valid[i] = 1'b0;
      if (!en) begin
        live[i]   = 1'b0;
        rise_t[i] = -1;
        fall_t[i] = -1;
      end else if (!live[i]) begin
        live[i]   = 1'b1;
        rise_t[i] = -1;
        fall_t[i] = -1;
      end else if (r) begin
        if (rise_t[i] >= 0 && fall_t[i] >= 0) begin
          h             = fall_t[i] - rise_t[i];
          l             = cyc - fall_t[i];
          exp_high[i]   = h;
          exp_low[i]    = l;
          exp_period[i] = h + l;
          exp_duty[i]   = (h - l <= 1) && (l - h <= 1);
          exp_valid[i]  = 1'b1;
          exp_stuck[i]  = 1'b0;
        end
        rise_t[i] = cyc;
        fall_t[i] = -1;
      end else if (f) begin
        if (rise_t[i] >= 0 && fall_t[i] < 0) fall_t[i] = cyc;
      end else if ((rise_t[i] >= 0 && fall_t[i] < 0 && cyc - rise_t[i] == cnt_max[i]) ||
                   (fall_t[i] >= 0 && cyc - fall_t[i] == cnt_max[i])) begin
        exp_stuck[i] = 1'b1;
        rise_t[i]    = -1;
        fall_t[i]    = -1;
      end
    end
    mhist = {mhist[1:0], sig_in};
  endtask

  task automatic checkAll();
    checkOutput("high16",   int'(high16),   exp_high[0]);
    checkOutput("low16",    int'(low16),    exp_low[0]);
    checkOutput("period16", int'(period16), exp_period[0]);
    checkOutput("duty16",   int'(duty16),   int'(exp_duty[0]));
    checkOutput("valid16",  int'(valid16),  int'(exp_valid[0]));
    checkOutput("stuck16",  int'(stuck16),  int'(exp_stuck[0]));
    checkOutput("high4",    int'(high4),    exp_high[1]);
    checkOutput("low4",     int'(low4),     exp_low[1]);
    checkOutput("period4",  int'(period4),  exp_period[1]);
    checkOutput("duty4",    int'(duty4),    int'(exp_duty[1]));
    checkOutput("valid4",   int'(valid4),   int'(exp_valid[1]));
    checkOutput("stuck4",   int'(stuck4),   int'(exp_stuck[1]));
  endtask

  // Called at a falling edge: drive inputs, let one rising edge pass, then
  // compare everything at the next falling edge.
  task automatic applyStimulus(input bit s, input bit e, input bit r);
    rst    = r;
    en     = e;
    sig_in = s;
    if (r) modelReset();
    @(posedge clk);
    if (rst) modelReset();
    else     modelEdge();
    cyc++;
    @(negedge clk);
    if (valid16) vcount16++;
    checkAll();
  endtask

  task automatic runPattern(input int hi, input int lo, input int reps);
    for (int p = 0; p < reps; p++) begin
      for (int k = 0; k < hi; k++) applyStimulus(1'b1, 1'b1, 1'b0);
      for (int k = 0; k < lo; k++) applyStimulus(1'b0, 1'b1, 1'b0);
    end
  endtask

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit dropped;
    bit found;
    int phase;
    int hl;
    int ll;
    cnt_max[0] = 65535;
    cnt_max[1] = 15;
    modelReset();
    rst    = 1'b1;
    en     = 1'b0;
    sig_in = 1'b0;
    @(negedge clk);

    // Reset state.
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("reset_period16", int'(period16), 0);
    checkOutput("reset_valid16",  int'(valid16),  0);
    checkOutput("reset_stuck4",   int'(stuck4),   0);

    // Divide-by-3: two high, one low.
    applyStimulus(1'b0, 1'b1, 1'b0);
    runPattern(2, 1, 6);
    vcount16 = 0;
    runPattern(2, 1, 3);
    checkOutput("div3_rate",   vcount16,       3);
    checkOutput("div3_high",   int'(high16),   2);
    checkOutput("div3_low",    int'(low16),    1);
    checkOutput("div3_period", int'(period16), 3);
    checkOutput("div3_duty",   int'(duty16),   1);
    checkOutput("div3_duty4",  int'(duty4),    1);

    // Divide-by-4.
    runPattern(2, 2, 6);
    vcount16 = 0;
    runPattern(2, 2, 3);
    checkOutput("div4_rate",   vcount16,       3);
    checkOutput("div4_high",   int'(high16),   2);
    checkOutput("div4_low",    int'(low16),    2);
    checkOutput("div4_period", int'(period16), 4);
    checkOutput("div4_duty",   int'(duty16),   1);

    // Drop en on the very edge where a closing rise is seen.
    dropped = 1'b0;
    phase   = 0;
    for (int k = 0; k < 8 && !dropped; k++) begin
      if (mhist[1] && !mhist[2]) begin
        applyStimulus((phase % 4) < 2, 1'b0, 1'b0);
        dropped = 1'b1;
      end else begin
        applyStimulus((phase % 4) < 2, 1'b1, 1'b0);
      end
      phase++;
    end
    checkOutput("endrop_found", int'(dropped), 1);
    checkOutput("endrop_valid", int'(valid16), 0);
    for (int k = 0; k < 5; k++) begin
      applyStimulus((phase % 4) < 2, 1'b0, 1'b0);
      phase++;
    end
    checkOutput("endrop_hold_high",   int'(high16),   2);
    checkOutput("endrop_hold_period", int'(period16), 4);
    vcount16 = 0;
    for (int k = 0; k < 5; k++) begin
      applyStimulus((phase % 4) < 2, 1'b1, 1'b0);
      phase++;
    end
    checkOutput("reenable_no_early_valid", vcount16, 0);
    for (int k = 0; k < 12; k++) begin
      applyStimulus((phase % 4) < 2, 1'b1, 1'b0);
      phase++;
    end
    checkOutput("reenable_period", int'(period16), 4);

    // Reset while measuring the low phase.
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      if (fall_t[0] >= 0) found = 1'b1;
      else begin
        applyStimulus((phase % 4) < 2, 1'b1, 1'b0);
        phase++;
      end
    end
    checkOutput("rstmid_in_low", int'(found), 1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("rstmid_high",   int'(high16),   0);
    checkOutput("rstmid_period", int'(period16), 0);
    checkOutput("rstmid_valid",  int'(valid16),  0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    vcount16 = 0;
    phase    = 0;
    for (int k = 0; k < 5; k++) begin
      applyStimulus((phase % 4) < 2, 1'b1, 1'b0);
      phase++;
    end
    checkOutput("rstmid_no_early_valid", vcount16, 0);
    runPattern(2, 2, 3);
    checkOutput("rstmid_after_period", int'(period16), 4);

    // Skewed 5 high / 1 low.
    runPattern(5, 1, 5);
    checkOutput("skew_period", int'(period16), 6);
    checkOutput("skew_duty",   int'(duty16),   0);
    checkOutput("skew_high4",  int'(high4),    5);

    // Saturation on the 4-bit monitor, then recovery.
    applyStimulus(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 20; k++) applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("sat_stuck4",  int'(stuck4),  1);
    checkOutput("sat_stuck16", int'(stuck16), 0);
    found = 1'b0;
    phase = 0;
    for (int k = 0; k < 30 && !found; k++) begin
      applyStimulus((phase % 6) >= 3, 1'b1, 1'b0);
      phase++;
      if (valid4) found = 1'b1;
    end
    checkOutput("sat_recover_seen", int'(found),   1);
    checkOutput("sat_recover_stuck", int'(stuck4), 0);
    checkOutput("sat_recover_period", int'(period4), 6);

    // Random run lengths with occasional disables and resets.
    for (int n = 0; n < 300; n++) begin
      hl = $urandom_range(1, 20);
      ll = $urandom_range(1, 20);
      if ($urandom_range(0, 39) == 0) begin
        applyStimulus(1'b0, 1'b1, 1'b1);
      end
      if ($urandom_range(0, 19) == 0) begin
        for (int k = 0; k < $urandom_range(1, 4); k++)
          applyStimulus($urandom_range(0, 1) == 1, 1'b0, 1'b0);
      end
      runPattern(hl, ll, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
